// File: rtl/radiant_scaler_bank.sv
// WISHBONE-mapped bank of prescaled, saturating rate scalers with a common timer/PPS snapshot.
// Optional build macro RADIANT_SCALER_MASK_EN adds a 64-bit per-channel count-enable mask.
module radiant_scaler_bank #(
    parameter int NUM_SCALERS    = 32,
    parameter int COUNT_WIDTH    = 16,
    parameter int PRESCALE_WIDTH = 8,
    parameter int PERIOD_DEFAULT = 50000000
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   pps_i,
    input  logic [NUM_SCALERS-1:0] scal_i,
    input  logic                   wb_cyc_i,
    input  logic                   wb_stb_i,
    input  logic                   wb_we_i,
    input  logic [15:0]            wb_adr_i,
    input  logic [31:0]            wb_dat_i,
    input  logic [3:0]             wb_sel_i,
    output logic [31:0]            wb_dat_o,
    output logic                   wb_ack_o,
    output logic                   wb_err_o,
    output logic                   wb_rty_o
);
    localparam logic [13:0] A_CTRL = 14'h000;
    localparam logic [13:0] A_PRE  = 14'h001;
    localparam logic [13:0] A_STAT = 14'h002;
    localparam logic [13:0] A_MLO  = 14'h003;
    localparam logic [13:0] A_MHI  = 14'h004;

    // Periods below 2 behave as 2; the down-counter reloads with period-1.
    function automatic logic [30:0] reload_of(input logic [30:0] p);
        return (p < 31'd2) ? 31'd1 : p - 31'd1;
    endfunction

    localparam logic [30:0] PERIOD_RST = 31'(PERIOD_DEFAULT);

    logic                      use_pps;
    logic [30:0]               period;
    logic [30:0]               timer;
    logic [5:0]                sel_ch;
    logic [15:0]               seq;
    logic                      pps_q, pps_q2;
    logic [PRESCALE_WIDTH-1:0] prescale [NUM_SCALERS];
    logic [PRESCALE_WIDTH-1:0] pre_cnt  [NUM_SCALERS];
    logic [COUNT_WIDTH-1:0]    live     [NUM_SCALERS];
    logic [COUNT_WIDTH-1:0]    snap     [NUM_SCALERS];
    logic [NUM_SCALERS-1:0]    inc;
    logic [NUM_SCALERS-1:0]    ch_en;
    logic [31:0]               rd_data;

    logic [13:0] wadr;
    logic        acc, wr, timer_tick, snap_evt, pre_wr;
    logic [5:0]  pre_tgt;

    assign wadr       = wb_adr_i[15:2];
    assign acc        = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign wr         = acc & wb_we_i;
    assign timer_tick = (timer == 31'd0);
    assign snap_evt   = use_pps ? (pps_q & ~pps_q2) : timer_tick;
    assign pre_wr     = wr && (wadr == A_PRE) && wb_sel_i[0];
    assign pre_tgt    = wb_sel_i[3] ? wb_dat_i[29:24] : sel_ch;
    assign wb_err_o   = 1'b0;
    assign wb_rty_o   = 1'b0;

    logic unused_bits;
    assign unused_bits = ^{wb_adr_i[1:0], wb_dat_i[23:PRESCALE_WIDTH], wb_sel_i[2:1]};

`ifdef RADIANT_SCALER_MASK_EN
    logic [63:0] mask;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mask <= '1;
        end else if (wr && (wadr == A_MLO || wadr == A_MHI)) begin
            for (int b = 0; b < 4; b++) begin
                if (wb_sel_i[b]) begin
                    if (wadr == A_MLO) mask[8*b +: 8] <= wb_dat_i[8*b +: 8];
                    else               mask[32+8*b +: 8] <= wb_dat_i[8*b +: 8];
                end
            end
        end
    end

    assign ch_en = mask[NUM_SCALERS-1:0];
`else
    assign ch_en = '1;
`endif

    always_comb begin
        inc = '0;
        for (int n = 0; n < NUM_SCALERS; n++)
            inc[n] = scal_i[n] && (pre_cnt[n] == prescale[n]);
    end

    always_comb begin
        rd_data = '0;
        if (wb_adr_i[15:8] == 8'h04) begin
            for (int n = 0; n < NUM_SCALERS; n++)
                if (wb_adr_i[7:2] == 6'(n)) rd_data = 32'(snap[n]);
        end else begin
            case (wadr)
                A_CTRL: rd_data = {use_pps, period};
                A_PRE: begin
                    rd_data[29:24] = sel_ch;
                    for (int n = 0; n < NUM_SCALERS; n++)
                        if (sel_ch == 6'(n)) rd_data[PRESCALE_WIDTH-1:0] = prescale[n];
                end
                A_STAT: rd_data = {16'h0000, seq};
`ifdef RADIANT_SCALER_MASK_EN
                A_MLO:  rd_data = mask[31:0];
                A_MHI:  rd_data = mask[63:32];
`endif
                default: rd_data = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
            use_pps  <= 1'b0;
            period   <= PERIOD_RST;
            timer    <= reload_of(PERIOD_RST);
            sel_ch   <= '0;
            seq      <= '0;
            pps_q    <= 1'b0;
            pps_q2   <= 1'b0;
        end else begin
            wb_ack_o <= acc;
            pps_q    <= pps_i;
            pps_q2   <= pps_q;
            if (acc)
                wb_dat_o <= rd_data;
            if (snap_evt)
                seq <= seq + 16'd1;
            // Timer free-runs in PPS mode too; only its tick is ignored there.
            if (wr && wadr == A_CTRL) begin
                use_pps <= wb_dat_i[31];
                period  <= wb_dat_i[30:0];
                timer   <= reload_of(wb_dat_i[30:0]);
            end else if (timer_tick) begin
                timer <= reload_of(period);
            end else begin
                timer <= timer - 31'd1;
            end
            if (wr && wadr == A_PRE && wb_sel_i[3])
                sel_ch <= wb_dat_i[29:24];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int n = 0; n < NUM_SCALERS; n++) begin
                prescale[n] <= '0;
                pre_cnt[n]  <= '0;
                live[n]     <= '0;
                snap[n]     <= '0;
            end
        end else begin
            for (int n = 0; n < NUM_SCALERS; n++) begin
                // A prescale write wins over counting: the live count restarts at 0.
                if (pre_wr && pre_tgt == 6'(n)) begin
                    prescale[n] <= wb_dat_i[PRESCALE_WIDTH-1:0];
                    pre_cnt[n]  <= '0;
                    live[n]     <= '0;
                end else if (!ch_en[n]) begin
                    pre_cnt[n] <= '0;
                    live[n]    <= '0;
                end else begin
                    if (scal_i[n])
                        pre_cnt[n] <= inc[n] ? '0 : pre_cnt[n] + PRESCALE_WIDTH'(1);
                    if (snap_evt)
                        live[n] <= COUNT_WIDTH'(inc[n]);
                    else if (inc[n] && live[n] != '1)
                        live[n] <= live[n] + COUNT_WIDTH'(1);
                end
                if (snap_evt)
                    snap[n] <= live[n];
            end
        end
    end
endmodule

// File: tb/tb_radiant_scaler_bank.sv
// Directed self-checking bench for radiant_scaler_bank (8 channels, 8-bit counters, 200-cycle default period).
module tb_radiant_scaler_bank;
    localparam int NS = 8;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        pps_i = 1'b0;
    logic [NS-1:0] scal_i = '0;
    logic        wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_we_i = 1'b0;
    logic [15:0] wb_adr_i = '0;
    logic [31:0] wb_dat_i = '0;
    logic [3:0]  wb_sel_i = '0;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o, wb_err_o, wb_rty_o;

    int n_vec = 0;
    int n_bad = 0;

    radiant_scaler_bank #(
        .NUM_SCALERS(NS), .COUNT_WIDTH(8), .PRESCALE_WIDTH(8), .PERIOD_DEFAULT(200)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .pps_i(pps_i), .scal_i(scal_i),
        .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
        .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o), .wb_rty_o(wb_rty_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Called at a negedge; the access is accepted at the next posedge, returns two negedges later.
    task automatic bus_wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
        wb_adr_i = a; wb_dat_i = d; wb_sel_i = s;
        @(negedge clk_i);
        n_vec++;
        if (wb_ack_o !== 1'b1) begin
            n_bad++;
            $display("FAIL wr_ack addr=%h: got %b want 1", a, wb_ack_o);
        end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic bus_rd(input logic [15:0] a, output logic [31:0] d);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0;
        wb_adr_i = a; wb_sel_i = 4'hF;
        @(negedge clk_i);
        n_vec++;
        if (wb_ack_o !== 1'b1) begin
            n_bad++;
            $display("FAIL rd_ack addr=%h: got %b want 1", a, wb_ack_o);
        end
        d = wb_dat_o;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic test_reset;
        logic [31:0] d;
        logic [31:0] exp_mask;
`ifdef RADIANT_SCALER_MASK_EN
        exp_mask = 32'hFFFF_FFFF;
`else
        exp_mask = 32'h0;
`endif
        rst_i = 1'b1;
        repeat (3) @(negedge clk_i);
        n_vec++;
        if (wb_ack_o !== 1'b0 || wb_dat_o !== 32'h0 || wb_err_o !== 1'b0 || wb_rty_o !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_outputs: got ack=%b dat=%h err=%b rty=%b want 0", wb_ack_o, wb_dat_o, wb_err_o, wb_rty_o);
        end
        rst_i = 1'b0;
        bus_rd(16'h0000, d);
        n_vec++;
        if (d !== 32'h0000_00C8) begin n_bad++; $display("FAIL reset_ctrl: got %h want 000000c8", d); end
        bus_rd(16'h0004, d);
        n_vec++;
        if (d !== 32'h0) begin n_bad++; $display("FAIL reset_prescale: got %h want 0", d); end
        bus_rd(16'h0008, d);
        n_vec++;
        if (d !== 32'h0) begin n_bad++; $display("FAIL reset_status: got %h want 0", d); end
        bus_rd(16'h0400, d);
        n_vec++;
        if (d !== 32'h0) begin n_bad++; $display("FAIL reset_snap0: got %h want 0", d); end
        bus_rd(16'h000C, d);
        n_vec++;
        if (d !== exp_mask) begin n_bad++; $display("FAIL reset_mask_lo: got %h want %h", d, exp_mask); end
        bus_rd(16'h0010, d);
        n_vec++;
        if (d !== exp_mask) begin n_bad++; $display("FAIL reset_mask_hi: got %h want %h", d, exp_mask); end
        bus_wr(16'h0020, 32'hDEAD_BEEF, 4'hF);
        bus_rd(16'h0020, d);
        n_vec++;
        if (d !== 32'h0) begin n_bad++; $display("FAIL unmapped_read: got %h want 0", d); end
    endtask

    task automatic test_back_to_back;
        logic [3:0] acks;
        logic [3:0] want;
        want = 4'b0101;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 16'h0008;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            acks[i] = wb_ack_o;
        end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        @(negedge clk_i);
        n_vec++;
        if (acks !== want) begin n_bad++; $display("FAIL held_strobe_acks: got %b want %b", acks, want); end
    endtask

    task automatic test_timer;
        logic [31:0] d, s1, s2, s3;
        scal_i = 8'h01;
        bus_wr(16'h0000, 32'd100, 4'hF);
        repeat (250) @(negedge clk_i);
        bus_rd(16'h0400, d);
        n_vec++;
        if (d !== 32'd100) begin n_bad++; $display("FAIL timer_snap0: got %0d want 100", d); end
        bus_rd(16'h0008, s1);
        repeat (98) @(negedge clk_i);
        bus_rd(16'h0008, s2);
        n_vec++;
        if (s2[15:0] - s1[15:0] !== 16'd1) begin n_bad++; $display("FAIL status_100: got delta %0d want 1", s2[15:0] - s1[15:0]); end
        repeat (298) @(negedge clk_i);
        bus_rd(16'h0008, s3);
        n_vec++;
        if (s3[15:0] - s2[15:0] !== 16'd3) begin n_bad++; $display("FAIL status_300: got delta %0d want 3", s3[15:0] - s2[15:0]); end
        // Period 1 is stored as written but runs as 2.
        bus_wr(16'h0000, 32'd1, 4'hF);
        bus_rd(16'h0000, d);
        n_vec++;
        if (d !== 32'd1) begin n_bad++; $display("FAIL ctrl_period1_read: got %h want 1", d); end
        bus_rd(16'h0008, s1);
        repeat (18) @(negedge clk_i);
        bus_rd(16'h0008, s2);
        n_vec++;
        if (s2[15:0] - s1[15:0] !== 16'd10) begin n_bad++; $display("FAIL status_period1: got delta %0d want 10", s2[15:0] - s1[15:0]); end
        bus_rd(16'h0400, d);
        n_vec++;
        if (d !== 32'd2) begin n_bad++; $display("FAIL snap_period1: got %0d want 2", d); end
        scal_i = '0;
    endtask

    task automatic test_prescale;
        logic [31:0] d;
        scal_i = '0;
        bus_wr(16'h0000, 32'd200, 4'hF);
        bus_wr(16'h0004, 32'h0300_0004, 4'b1001);
        scal_i[3] = 1'b1;
        repeat (50) @(negedge clk_i);
        scal_i[3] = 1'b0;
        repeat (160) @(negedge clk_i);
        bus_rd(16'h040C, d);
        n_vec++;
        if (d !== 32'd10) begin n_bad++; $display("FAIL prescale_snap3: got %0d want 10", d); end
        bus_rd(16'h0004, d);
        n_vec++;
        if (d !== 32'h0300_0004) begin n_bad++; $display("FAIL prescale_read: got %h want 03000004", d); end
        bus_rd(16'h0420, d);
        n_vec++;
        if (d !== 32'h0) begin n_bad++; $display("FAIL snap_out_of_range: got %h want 0", d); end
    endtask

    task automatic test_saturate;
        logic [31:0] d;
        scal_i = 8'h20;
        bus_wr(16'h0000, 32'd1000, 4'hF);
        repeat (2100) @(negedge clk_i);
        bus_rd(16'h0414, d);
        n_vec++;
        if (d !== 32'h0000_00FF) begin n_bad++; $display("FAIL saturate_snap5: got %h want ff", d); end
        scal_i = '0;
    endtask

    task automatic test_prescale_vs_snapshot;
        logic [31:0] d;
        scal_i = '0;
        bus_wr(16'h0004, 32'h0200_0000, 4'b1001);
        bus_wr(16'h0000, 32'd100, 4'hF);
        scal_i[2] = 1'b1;
        repeat (98) @(negedge clk_i);
        // This write lands on the same edge as the snapshot.
        bus_wr(16'h0004, 32'h0200_0000, 4'b1001);
        bus_rd(16'h0408, d);
        n_vec++;
        if (d !== 32'd98) begin n_bad++; $display("FAIL coincide_old_count: got %0d want 98", d); end
        repeat (100) @(negedge clk_i);
        bus_rd(16'h0408, d);
        n_vec++;
        if (d !== 32'd99) begin n_bad++; $display("FAIL coincide_next_count: got %0d want 99", d); end
        scal_i = '0;
    endtask

    task automatic test_pps;
        logic [31:0] d, s0;
        scal_i = 8'h02;
        bus_wr(16'h0004, 32'h0100_0018, 4'b1001);
        bus_wr(16'h0000, 32'h8000_0064, 4'hF);
        bus_rd(16'h0008, s0);
        for (int p = 0; p < 3; p++) begin
            pps_i = 1'b1;
            repeat (20) @(negedge clk_i);
            pps_i = 1'b0;
            bus_rd(16'h0008, d);
            n_vec++;
            if (d[15:0] - s0[15:0] !== 16'(p + 1)) begin
                n_bad++;
                $display("FAIL pps_status pulse %0d: got delta %0d want %0d", p, d[15:0] - s0[15:0], p + 1);
            end
            repeat (4978) @(negedge clk_i);
        end
        bus_rd(16'h0404, d);
        n_vec++;
        if (d !== 32'd200) begin n_bad++; $display("FAIL pps_snap1: got %0d want 200", d); end
        scal_i = '0;
    endtask

    task automatic test_mask;
        logic [31:0] d, exp0, expm;
`ifdef RADIANT_SCALER_MASK_EN
        exp0 = 32'd0;
        expm = 32'hFFFF_FFFE;
`else
        exp0 = 32'd100;
        expm = 32'h0;
`endif
        scal_i = '1;
        bus_wr(16'h0004, 32'h0100_0000, 4'b1001);
        bus_wr(16'h000C, 32'hFFFF_FFFE, 4'hF);
        bus_wr(16'h0000, 32'd100, 4'hF);
        repeat (250) @(negedge clk_i);
        bus_rd(16'h0400, d);
        n_vec++;
        if (d !== exp0) begin n_bad++; $display("FAIL mask_snap0: got %0d want %0d", d, exp0); end
        bus_rd(16'h0404, d);
        n_vec++;
        if (d !== 32'd100) begin n_bad++; $display("FAIL mask_snap1: got %0d want 100", d); end
        bus_rd(16'h000C, d);
        n_vec++;
        if (d !== expm) begin n_bad++; $display("FAIL mask_read: got %h want %h", d, expm); end
        scal_i = '0;
    endtask

    task automatic test_reset_midop;
        logic [31:0] d;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 16'h0008;
        rst_i = 1'b1;
        @(negedge clk_i);
        n_vec++;
        if (wb_ack_o !== 1'b0) begin n_bad++; $display("FAIL midop_ack: got %b want 0", wb_ack_o); end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
        bus_rd(16'h0008, d);
        n_vec++;
        if (d !== 32'h0) begin n_bad++; $display("FAIL midop_status: got %h want 0", d); end
        bus_rd(16'h0404, d);
        n_vec++;
        if (d !== 32'h0) begin n_bad++; $display("FAIL midop_snap1: got %h want 0", d); end
        bus_rd(16'h0000, d);
        n_vec++;
        if (d !== 32'h0000_00C8) begin n_bad++; $display("FAIL midop_ctrl: got %h want 000000c8", d); end
    endtask

    initial begin
        test_reset;
        test_back_to_back;
        test_timer;
        test_prescale;
        test_saturate;
        test_prescale_vs_snapshot;
        test_pps;
        test_mask;
        test_reset_midop;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/radiant_scaler_bank.md
# radiant_scaler_bank

Parametrised, WISHBONE-mapped bank of prescalable rate scalers for the RADIANT trigger path. It supersedes the fixed dual-packed scaler block with configurable channel count, counter width and prescale width, per-channel prescale readback, saturating counters, a snapshot sequence number, and an optional channel mask. It sits on the 50 MHz control WISHBONE bus. All `NUM_SCALERS` counters are snapshotted simultaneously on either an internal period timer or PPS.

## Interface
- `NUM_SCALERS`, 32: channel count, 1..64.
- `COUNT_WIDTH`, 16: live/snapshot counter width, 1..32.
- `PRESCALE_WIDTH`, 8: per-channel prescale width, 1..16.
- `PERIOD_DEFAULT`, 50000000: timer period in clk cycles after reset.

Ports:
- `clk_i`  in  1  50 MHz clock; the only clock.
- `rst_i`  in  1  asynchronous, active-high reset.
- `pps_i`  in  1  PPS, already in the `clk_i` domain.
- `scal_i`  in  NUM_SCALERS  per-channel trigger level; counted each cycle it is high.
- `wb_cyc_i`, `wb_stb_i`, `wb_we_i`  in  1 each  WISHBONE cycle, strobe and write enable.
- `wb_adr_i`  in  16  byte address.
- `wb_dat_i`  in  32  write data.
- `wb_sel_i`  in  4  byte selects.
- `wb_dat_o`  out  32  read data.
- `wb_ack_o`  out  1  acknowledge.
- `wb_err_o`, `wb_rty_o`  out  1 each  tied 0.

## Operation
Register map (word-aligned; bits [1:0] ignored):
- 0x000 CTRL: [31] `use_pps`; [30:0] period in clk cycles. Any write restarts the timer. A period < 2 is stored as written but acts as 2.
- 0x004 PRESCALE: [29:24] channel select, [PRESCALE_WIDTH-1:0] prescale value. A write with `wb_sel_i[3]` set updates the select. A write with `wb_sel_i[0]` also writes the prescale of the selected channel and clears its live and prescale counters. Read returns the select and the selected channel's prescale.
- 0x008 STATUS (read only): [15:0] snapshot sequence number. Increments on every snapshot; wraps 0xFFFF->0x0000.
- 0x00C/0x010 MASK low/high: see Configuration.
- 0x400+4n: snapshot of channel n, zero-extended. n >= NUM_SCALERS reads 0.
- Other addresses read 0; writes to them are ignored but still acknowledged.

Counting, per channel:
- Prescale counter runs when `scal_i[n]`=1. When it equals the channel prescale P, it returns to 0 and the live counter increments. Result: one count per P+1 high cycles.
- Live counter saturates at 2^COUNT_WIDTH-1.

Snapshot:
- Trigger: timer tick when `use_pps`=0; rising edge of `pps_i` when `use_pps`=1. The timer keeps running in PPS mode, but its ticks are ignored.
- On snapshot, all snapshot registers load their live counters and all live counters restart. A live increment in the snapshot cycle counts into the new interval (counter loads 1, not 0).
- Snapshot coinciding with a PRESCALE write to channel n: snapshot captures the old count, and the live counter restarts at 0.
- Reset values: all counters, snapshots and sequence number 0; prescales 0 (divide by 1); period PERIOD_DEFAULT; `use_pps` 0; select 0; mask all ones; `wb_ack_o` 0; `wb_dat_o` 0.

## Timing
- `wb_ack_o` rises the cycle after the first cycle of `wb_cyc_i & wb_stb_i` and lasts one cycle. It is not reasserted in its own ack cycle, so a held strobe acks every 2 cycles.
- `wb_dat_o` is registered and valid with `wb_ack_o`. It reflects the register state at the edge where the strobe was first sampled.
- Write data takes effect at that same edge.
- Timer mode: first snapshot exactly `period` cycles after reset release or a CTRL write, then every `period` cycles.
- PPS mode: `pps_i` is sampled into a register. A rise seen at edge t snapshots at edge t+1. A PPS held high gives one snapshot.
- Mid-operation `rst_i` clears everything immediately; an in-flight WISHBONE access is dropped without ack.

## Configuration
- `RADIANT_SCALER_MASK_EN` defined: adds 64-bit MASK (0x00C = channels 31:0, 0x010 = channels 63:32), read/write, byte-selectable, reset all ones. A masked channel (bit 0) holds its live and prescale counters at 0, so its snapshot reads 0.
- Not defined: MASK addresses read 0, writes are ignored, and all channels always count.

## Test plan
- Reset, `scal_i`[0] held high, period=100, prescale 0 -> snapshot 0x400 reads 100; STATUS increments by 1 every 100 cycles.
- Channel 3 prescale=4, `scal_i[3]` high for 50 cycles within one period -> 0x40C reads 10; PRESCALE read with select 3 returns 0x03000004.
- COUNT_WIDTH=8, channel held high for 1000 cycles, prescale 0 -> snapshot reads 0xFF (saturated).
- `use_pps`=1, `pps_i` pulses 5000 cycles apart, channel 1 high continuously -> 0x404 reads 5000; no snapshots between pulses; STATUS increments once per pulse.
- PRESCALE write to channel 2 in the same cycle as a snapshot -> snapshot keeps the old count; the next snapshot counts only from the write.
- With `RADIANT_SCALER_MASK_EN` defined, write 0xFFFFFFFE to 0x00C, all inputs high -> 0x400 reads 0 and 0x404 reads the full count. Without the macro, 0x00C reads 0.
